// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, state and ALU-op encodings shared by the control FSM and datapath
package ctrl_pkg;
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_NEG = 2'b10
  } alu_op_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_NOP, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
                      OP_J, OP_BRZ, OP_BRN, OP_LD, OP_SVPC};
  endfunction
endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer with bounded memory handshakes
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       alu_src_imm,
  output logic       alu_src_pc,
  output logic [1:0] alu_op,
  output logic       flag_we,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       halted,
  output logic       bus_err,
  output logic [2:0] state_o
);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  state_t            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_halted;
  logic              r_bus_err;

  logic w_fetch, w_dec, w_exec, w_mem, w_wb;
  logic w_nop, w_j, w_brz, w_brn, w_add, w_inc, w_neg, w_sub, w_ld, w_st, w_svpc;
  logic w_legal, w_dec_pc, w_ack, w_timeout;
  logic [WAIT_W-1:0] w_cnt_inc;

  // strobes are forced low while reset is held, so state decodes carry rst_n
  assign w_fetch = rst_n && r_state == S_FETCH;
  assign w_dec   = rst_n && r_state == S_DECODE;
  assign w_exec  = rst_n && r_state == S_EXEC;
  assign w_mem   = rst_n && r_state == S_MEM;
  assign w_wb    = rst_n && r_state == S_WB;

  assign w_nop  = opcode == OP_NOP;
  assign w_j    = opcode == OP_J;
  assign w_brz  = opcode == OP_BRZ;
  assign w_brn  = opcode == OP_BRN;
  assign w_add  = opcode == OP_ADD;
  assign w_inc  = opcode == OP_INC;
  assign w_neg  = opcode == OP_NEG;
  assign w_sub  = opcode == OP_SUB;
  assign w_ld   = opcode == OP_LD;
  assign w_st   = opcode == OP_ST;
  assign w_svpc = opcode == OP_SVPC;

  assign w_legal  = is_legal(opcode);
  assign w_dec_pc = w_nop || w_j || w_brz || w_brn;

  // only the ack belonging to the current access is looked at
  assign w_ack     = r_state == S_FETCH ? imem_ack : dmem_ack;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = w_cnt_inc == LIMIT;

  assign imem_req    = w_fetch;
  assign ir_we       = w_fetch && imem_ack;
  assign dmem_req    = w_mem;
  assign dmem_we     = w_mem && w_st;
  assign pc_we       = (w_dec && w_dec_pc) || (w_mem && w_st && dmem_ack) || w_wb;
  assign pc_src      = w_dec && (w_j || (w_brz && flag_z) || (w_brn && flag_n));
  assign alu_src_imm = w_exec && (w_inc || w_ld || w_st || w_svpc);
  assign alu_src_pc  = w_exec && w_svpc;
  assign alu_op      = !w_exec ? ALU_ADD : w_sub ? ALU_SUB : w_neg ? ALU_NEG : ALU_ADD;
  assign flag_we     = w_exec && (w_add || w_sub || w_inc || w_neg);
  assign reg_we      = w_wb;
  assign wb_sel      = w_wb && w_ld;
  assign halted      = r_halted;
  assign bus_err     = r_bus_err;
  assign state_o     = r_state;

  // sequencing, wait counting (cleared on every state change) and sticky halt status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_FETCH, S_MEM: begin
          r_state   <= w_ack ? (r_state == S_FETCH ? S_DECODE : w_st ? S_FETCH : S_WB)
                             : w_timeout ? S_HALT : r_state;
          r_halted  <= !w_ack && w_timeout;
          r_bus_err <= !w_ack && w_timeout;
          if (!w_ack && !w_timeout) r_cnt <= w_cnt_inc;
        end
        S_DECODE: begin
          r_state  <= !w_legal ? S_HALT : w_dec_pc ? S_FETCH : S_EXEC;
          r_halted <= !w_legal;
        end
        S_EXEC: r_state <= (w_ld || w_st) ? S_MEM : S_WB;
        S_WB:   r_state <= S_FETCH;
        default: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction cycle-trace model compared against the control FSM
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int MW = 15;
  localparam logic [12:0] IREQ  = 13'h1000;
  localparam logic [12:0] DREQ  = 13'h0800;
  localparam logic [12:0] DWE   = 13'h0400;
  localparam logic [12:0] IRWE  = 13'h0200;
  localparam logic [12:0] PCWE  = 13'h0100;
  localparam logic [12:0] PCSRC = 13'h0080;
  localparam logic [12:0] IMM   = 13'h0040;
  localparam logic [12:0] APC   = 13'h0020;
  localparam logic [12:0] OPNEG = 13'h0010;
  localparam logic [12:0] OPSUB = 13'h0008;
  localparam logic [12:0] FWE   = 13'h0004;
  localparam logic [12:0] RWE   = 13'h0002;
  localparam logic [12:0] WBS   = 13'h0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = '0;
  logic       flag_z = 1'b0, flag_n = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_src_imm, alu_src_pc;
  logic [1:0] alu_op;
  logic       flag_we, reg_we, wb_sel, halted, bus_err;
  logic [2:0] state_o;
  logic [12:0] w_obs;

  typedef struct {
    logic [2:0]  st;
    logic [12:0] o;
    logic        ack;
  } cyc_t;

  cyc_t q[$];
  int total = 0;
  int bad = 0;
  int res;

  multicycle_ctrl #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_z(flag_z), .flag_n(flag_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc), .alu_op(alu_op),
    .flag_we(flag_we), .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted),
    .bus_err(bus_err), .state_o(state_o)
  );

  assign w_obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_src_imm,
                  alu_src_pc, alu_op, flag_we, reg_we, wb_sel};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [12:0] o, input logic ack);
    cyc_t c;
    c.st = st;
    c.o = o;
    c.ack = ack;
    q.push_back(c);
  endtask

  // expected cycle trace of one instruction; res: 0 normal, 1 timeout halt, 2 illegal halt
  task automatic gen(input logic [3:0] op, input logic fz, input logic fn,
                     input int iw, input int dw, output int r);
    logic [12:0] o;
    q.delete();
    r = 0;
    for (int k = 0; k < iw && k < MW; k++) push(3'd0, IREQ, 1'b0);
    if (iw >= MW) begin r = 1; return; end
    push(3'd0, IREQ | IRWE, 1'b1);
    if (op inside {OP_NOP, OP_J, OP_BRZ, OP_BRN}) begin
      o = PCWE;
      if (op == OP_J || (op == OP_BRZ && fz) || (op == OP_BRN && fn)) o |= PCSRC;
      push(3'd1, o, 1'b0);
      return;
    end
    push(3'd1, 13'h0, 1'b0);
    if (!(op inside {OP_ADD, OP_INC, OP_NEG, OP_SUB, OP_LD, OP_ST, OP_SVPC})) begin
      r = 2;
      return;
    end
    o = 13'h0;
    if (op inside {OP_INC, OP_LD, OP_ST, OP_SVPC}) o |= IMM;
    if (op == OP_SVPC) o |= APC;
    if (op == OP_SUB) o |= OPSUB;
    if (op == OP_NEG) o |= OPNEG;
    if (op inside {OP_ADD, OP_SUB, OP_INC, OP_NEG}) o |= FWE;
    push(3'd2, o, 1'b0);
    if (op == OP_LD || op == OP_ST) begin
      o = (op == OP_ST) ? (DREQ | DWE) : DREQ;
      for (int k = 0; k < dw && k < MW; k++) push(3'd3, o, 1'b0);
      if (dw >= MW) begin r = 1; return; end
      push(3'd3, (op == OP_ST) ? (o | PCWE) : o, 1'b1);
      if (op == OP_ST) return;
    end
    push(3'd4, (op == OP_LD) ? (RWE | PCWE | WBS) : (RWE | PCWE), 1'b0);
  endtask

  task automatic play(input string tag, input logic [3:0] op, input logic fz,
                      input logic fn, input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      opcode   = (c.st == 3'd0) ? 4'($urandom) : op;
      flag_z   = (c.st == 3'd1) ? fz : 1'($urandom);
      flag_n   = (c.st == 3'd1) ? fn : 1'($urandom);
      imem_ack = (c.st == 3'd0) ? c.ack : 1'($urandom);
      dmem_ack = (c.st == 3'd3) ? c.ack : 1'($urandom);
      #1;
      chk({tag, " state"}, 16'(state_o), 16'(c.st));
      chk({tag, " strobes"}, 16'(w_obs), 16'(c.o));
      chk({tag, " status"}, {14'd0, halted, bus_err}, 16'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic halt_chk(input string tag, input logic b, input int n, input logic force_ack);
    for (int i = 0; i < n; i++) begin
      opcode   = 4'($urandom);
      flag_z   = 1'($urandom);
      flag_n   = 1'($urandom);
      imem_ack = force_ack ? 1'b1 : 1'($urandom);
      dmem_ack = 1'($urandom);
      #1;
      chk({tag, " halt state"}, 16'(state_o), 16'd7);
      chk({tag, " halt strobes"}, 16'(w_obs), 16'd0);
      chk({tag, " halt status"}, {14'd0, halted, bus_err}, {14'd0, 1'b1, b});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag, input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      opcode   = 4'($urandom);
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      #1;
      chk({tag, " rst strobes"}, 16'(w_obs), 16'd0);
      if (i > 0) begin
        chk({tag, " rst state"}, 16'(state_o), 16'd0);
        chk({tag, " rst status"}, {14'd0, halted, bus_err}, 16'd0);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic fz,
                     input logic fn, input int iw, input int dw);
    int r;
    gen(op, fz, fn, iw, dw, r);
    play(tag, op, fz, fn, 1000);
    if (r != 0) begin
      halt_chk(tag, r == 1, 3, r == 1);
      do_reset(tag, 2);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset("init", 3);
    run("add", OP_ADD, 1'b0, 1'b0, 0, 0);
    run("ld", OP_LD, 1'b0, 1'b0, 0, 3);
    run("brz", OP_BRZ, 1'b1, 1'b0, 0, 0);
    run("brn", OP_BRN, 1'b0, 1'b0, 0, 0);
    run("inc", OP_INC, 1'b0, 1'b0, 1, 0);
    run("svpc", OP_SVPC, 1'b0, 1'b0, 0, 0);
    run("st", OP_ST, 1'b0, 1'b0, 2, 1);
    run("j", OP_J, 1'b0, 1'b1, 0, 0);
    run("illegal", 4'b0001, 1'b0, 1'b0, 0, 0);
    run("imem_to", OP_ADD, 1'b0, 1'b0, 15, 0);
    run("imem_edge", OP_NEG, 1'b0, 1'b0, 14, 0);
    run("dmem_edge", OP_LD, 1'b0, 1'b0, 0, 14);
    run("dmem_to", OP_ST, 1'b0, 1'b0, 0, 15);
    gen(OP_ST, 1'b0, 1'b0, 0, 5, res);
    play("rst_mid", OP_ST, 1'b0, 1'b0, 4);
    do_reset("rst_mid", 3);
    q.delete();
    run("after_rst", OP_SUB, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 150; i++) begin
      run("rand", 4'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 16)) : int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 16)) : int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the 32-bit single-issue core.
- Sequences fetch, decode, execute, memory and writeback, and steers the datapath muxes, including the select that routes the sign-extended 16-bit immediate into the ALU.
- Talks to instruction and data memory via req/ack handshakes, with a bounded wait.
- Sits between the IR/flag registers and every datapath write-enable.

Parameters:
- MAX_WAIT, 15: maximum cycles a memory req may stay unacknowledged before a bus error.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  4  IR[31:28]; valid from DECODE onward
- flag_z  in  1  registered zero flag from the last flag-writing ALU op
- flag_n  in  1  registered negative flag
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction word valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (valid with dmem_req)
- dmem_ack  in  1  data access complete this cycle
- ir_we  out  1  load IR
- pc_we  out  1  update PC
- pc_src  out  1  0 = PC+1, 1 = register target (rs)
- alu_src_imm  out  1  ALU B operand = sign-extended imm16 (else rt)
- alu_src_pc  out  1  ALU A operand = PC (else rs)
- alu_op  out  2  00 ADD, 01 SUB, 10 NEG(B)
- flag_we  out  1  latch Z/N flags
- reg_we  out  1  register-file write
- wb_sel  out  1  0 = ALU result, 1 = dmem read data
- halted  out  1  FSM in HALT
- bus_err  out  1  sticky; set when HALT is entered via timeout
- state_o  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. All outputs except halted, bus_err and state_o are combinational from state and opcode.
- Reset: while rst_n=0, every strobe output is 0. On the next edge: state=FETCH, wait count=0, halted=0, bus_err=0. Reset mid-access drops dmem_req/imem_req immediately and no write-back is issued.
- Opcodes, as defined in the shared package:
  - NOP 0000, ADD 0100, INC 0101 (rd=rs+imm), NEG 0110, SUB 0111
  - J 1000, BRZ 1001, BRN 1011
  - ST 0011, LD 1110 (address = rs+imm)
  - SVPC 1111 (rd=PC+imm)
  - Any other opcode is illegal.
- FETCH: imem_req=1 until imem_ack. On the ack cycle, ir_we=1 and next state is DECODE.
- DECODE, one cycle:
  - illegal -> HALT
  - NOP -> pc_we=1, pc_src=0, FETCH
  - J -> pc_we=1, pc_src=1, FETCH
  - BRZ/BRN -> pc_we=1, pc_src=flag_z or flag_n respectively, FETCH
  - everything else -> EXEC
- EXEC, one cycle:
  - alu_src_imm=1 for INC/LD/ST/SVPC.
  - alu_src_pc=1 for SVPC only.
  - alu_op: SUB=01, NEG=10, all others 00.
  - flag_we=1 for ADD/SUB/INC/NEG.
  - Next state: MEM for LD/ST, else WB.
- MEM: dmem_req=1, dmem_we=(ST). Held until dmem_ack. On ack: ST -> pc_we=1, pc_src=0, FETCH; LD -> WB.
- WB: reg_we=1, wb_sel=(LD), pc_we=1, pc_src=0, next FETCH.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle FETCH/MEM waits without ack.
  - If it equals MAX_WAIT with no ack -> HALT and bus_err=1.
  - Ack in the same cycle as the limit: ack wins, normal transition.
- Ignored inputs: ack while not requesting; imem_ack during MEM; dmem_ack during FETCH.
- HALT is absorbing: all strobes 0, halted=1. Only rst_n exits.
- Latency with zero-wait memory, from fetch-request cycle to the next fetch request:
  - NOP/J/branch: 2 cycles
  - ALU/SVPC/ST: 4 cycles
  - LD: 5 cycles
- Each memory wait cycle adds 1.

Decomposition:
- Package ctrl_pkg holds:
  - the opcode localparams
  - the state encoding
  - the alu_op encoding, shared with the ALU
- No sub-module: the wait counter stays inline.

Test Plan:
- rst_n low 3 cycles mid-MEM with a ST in flight -> strobes 0 while low; state_o=0 one cycle after release; no dmem_we pulse after reset asserts.
- ADD with imem_ack at first req -> ir_we@c0, flag_we@c2, reg_we+pc_we@c3 with wb_sel=0, imem_req again @c4.
- LD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; then WB: reg_we=1, wb_sel=1.
- BRZ with flag_z=1, then BRN with flag_n=0 -> pc_src=1 then 0; both pc_we in DECODE; no EXEC visited.
- imem_ack withheld 15 cycles (MAX_WAIT=15) -> halted=1, bus_err=1; a later ack is ignored until reset. Repeat with ack on exactly the 15th cycle -> normal DECODE.
- Opcode 0001 -> HALT from DECODE with bus_err=0; INC/SVPC -> alu_src_imm=1 in EXEC, and alu_src_pc=1 for SVPC only.
